// File: rtl/axis_1553_encoder_if.sv
// AXI-Stream word channel into the 1553 encoder: 16-bit word plus sync/option flags.
interface axis_1553_encoder_if;
  logic [15:0] tdata;
  logic [7:0]  tuser;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tuser, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tvalid, output tready);
endinterface

// File: rtl/axis_1553_encoder.sv
// AXI-Stream to MIL-STD-1553 Manchester-II encoder (1 Mbit/s), one-word holding register.
// Optional parity error injection via tuser[1] when AXIS_1553_ENCODER_PARITY_ERR_EN is defined.
module axis_1553_encoder #(
  parameter int clock_speed = 100000000,
  parameter int delay       = 0
) (
  input  logic                aclk,
  input  logic                arstn,
  axis_1553_encoder_if.slave  s_axis,
  output logic [1:0]          diff
);

  localparam int CPB  = clock_speed / 1000000;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(3 * CPB);
  localparam int GW   = (delay > 1) ? $clog2(delay) : 1;

  localparam logic [CW-1:0] SYNC_LAST = CW'(3 * CPB - 1);
  localparam logic [CW-1:0] SYNC_MID  = CW'(3 * HALF);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] BIT_MID   = CW'(HALF);
  localparam logic [GW-1:0] GAP_LAST  = GW'((delay > 0) ? delay - 1 : 0);

  if (clock_speed % 2000000 != 0) begin : g_bad_clock
    $error("axis_1553_encoder: clock_speed must be an integer multiple of 2000000");
  end

  typedef enum logic [2:0] {IDLE, SYNC, DATA, PARITY, GAP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    bit_cnt, bit_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic [1:0]    diff_n;
  logic          load, shift, line, active;

  logic          ready_en, hold_valid, hold_cmd, hold_perr;
  logic [15:0]   hold_data;
  logic [15:0]   shreg;
  logic          sync_cmd, par_bit;
  logic          perr_in, xfer;

`ifdef AXIS_1553_ENCODER_PARITY_ERR_EN
  logic unused_tuser;
  assign unused_tuser = ^s_axis.tuser[7:2];
  assign perr_in      = s_axis.tuser[1];
`else
  logic unused_tuser;
  assign unused_tuser = ^s_axis.tuser[7:1];
  assign perr_in      = 1'b0;
`endif

  assign s_axis.tready = ready_en & ~hold_valid;
  assign xfer          = s_axis.tvalid & s_axis.tready;

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      ready_en   <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_cmd   <= 1'b0;
      hold_perr  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (load) begin
        hold_valid <= 1'b0;
      end else if (xfer) begin
        hold_valid <= 1'b1;
        hold_data  <= s_axis.tdata;
        hold_cmd   <= s_axis.tuser[0];
        hold_perr  <= perr_in;
      end
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      diff     <= 2'b00;
      shreg    <= '0;
      sync_cmd <= 1'b0;
      par_bit  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_n;
      gap_cnt <= gap_n;
      diff    <= diff_n;
      if (load) begin
        shreg    <= hold_data;
        sync_cmd <= hold_cmd;
        par_bit  <= ~(^hold_data) ^ hold_perr;
      end else if (shift) begin
        shreg <= {shreg[14:0], 1'b0};
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_cnt;
    gap_n   = gap_cnt;
    load    = 1'b0;
    shift   = 1'b0;
    line    = 1'b0;
    active  = 1'b0;
    unique case (state)
      IDLE: begin
        if (hold_valid) begin
          load    = 1'b1;
          cnt_n   = '0;
          state_n = SYNC;
        end
      end
      SYNC: begin
        active = 1'b1;
        line   = (cnt < SYNC_MID) ? ~sync_cmd : sync_cmd;
        if (cnt == SYNC_LAST) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        active = 1'b1;
        line   = (cnt < BIT_MID) ? ~shreg[15] : shreg[15];
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          shift = 1'b1;
          bit_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) state_n = PARITY;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PARITY: begin
        active = 1'b1;
        line   = (cnt < BIT_MID) ? ~par_bit : par_bit;
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (delay > 0) begin
            gap_n   = '0;
            state_n = GAP;
          end else if (hold_valid) begin
            load    = 1'b1;
            state_n = SYNC;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GAP: begin
        // A pending word starts straight from the last gap cycle so the idle
        // run on the line is exactly 'delay' samples long.
        if (gap_cnt == GAP_LAST) begin
          if (hold_valid) begin
            load    = 1'b1;
            state_n = SYNC;
          end else begin
            state_n = IDLE;
          end
        end else begin
          gap_n = gap_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    diff_n = active ? {~line, line} : 2'b00;
  end

endmodule
